dm_port_arbiter: RTL

Two-port round-robin arbiter and access sequencer in front of the 256×16 data memory. It lets two requesters share the memory's single addr/wen/wdata/rdata port: port 0 is the core load/store stage and port 1 is the debug/DMA loader. It latches one request at a time, drives the memory for one cycle and registers the read data. It then returns a one-cycle acknowledge, with an error flag if the address is out of range.

---
 rtl/dm_port_arbiter.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/dm_port_arbiter.sv
// -----------------------------------------------------------------------------
// dm_port_arbiter
//
// Two-port round-robin arbiter and access sequencer in front of the single-port
// 256x16 data memory. Port 0 is the core load/store stage and port 1 is the
// debug/DMA loader. One request is latched at a time. The memory is driven for
// one cycle (ACCESS), and the read data and error flag are registered. A
// one-cycle acknowledge is then returned to the winning port (DONE).
//
// Parameters:
//   ADDR_LIMIT      number of valid word addresses; addr >= ADDR_LIMIT is
//                   rejected (no write, rdata = 0, err = 1)
//
// Ports:
//   clk             single clock, rising edge
//   rst             asynchronous, active-low reset
//   req0/req1       request from port n, held high until ackn
//   we0/we1         1 = write, 0 = read, sampled with reqn
//   addr0/addr1     word address
//   wdata0/wdata1   write data
//   ack0/ack1       one-cycle completion pulse to port n
//   err             valid with ack*: address was out of range
//   rdata           valid with ack* for reads (0 for writes / bad addresses)
//   dm_addr         address to data memory (holds last latched value)
//   dm_wen          write enable to data memory (only in ACCESS)
//   dm_wdata        write data to data memory (holds last latched value)
//   dm_rdata        combinational read data from data memory
//
// Timing: a request sampled at edge E0 runs ACCESS in E0-E1. The memory write
// commits at E1, and ack/rdata/err are visible in E1-E2. One transaction
// completes every 3 cycles.
// -----------------------------------------------------------------------------
module dm_port_arbiter #(
  parameter int ADDR_LIMIT = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [15:0] addr0,
  input  logic [15:0] addr1,
  input  logic [15:0] wdata0,
  input  logic [15:0] wdata1,
  output logic        ack0,
  output logic        ack1,
  output logic        err,
  output logic [15:0] rdata,
  output logic [15:0] dm_addr,
  output logic        dm_wen,
  output logic [15:0] dm_wdata,
  input  logic [15:0] dm_rdata
);

  // Limit widened to 32 bits so the unsigned compare against a 16-bit address
  // stays correct even for a limit of 65536.
  localparam logic [31:0] LIMIT = 32'(ADDR_LIMIT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic        last;       // port that won the previous arbitration
  logic        lat_port;
  logic        lat_we;
  logic        lat_bad;
  logic [15:0] lat_addr;
  logic [15:0] lat_wdata;

  logic        any_req;
  logic        grant;
  logic        sel_we;
  logic        sel_bad;
  logic [15:0] sel_addr;
  logic [15:0] sel_wdata;

  // Arbitration, request select and next-state decode.
  // NOTE: every signal gets a default at the top of the block so that no path
  // leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    any_req   = req0 | req1;
    grant     = 1'b0;
    state_nxt = state;

    // On a tie, the port that did not win last time is served.
    if (req0 && req1) begin
      grant = ~last;
    end else if (req1) begin
      grant = 1'b1;
    end

    sel_we    = grant ? we1    : we0;
    sel_addr  = grant ? addr1  : addr0;
    sel_wdata = grant ? wdata1 : wdata0;
    sel_bad   = ({16'b0, sel_addr} >= LIMIT);

    unique case (state)
      IDLE:    if (any_req) state_nxt = ACCESS;
      ACCESS:  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, round-robin pointer, request latches and result registers.
  // NOTE: sequential state is written only with non-blocking assignments, so
  // every register samples its inputs as they were just before the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      last      <= 1'b1;
      lat_port  <= 1'b0;
      lat_we    <= 1'b0;
      lat_bad   <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      rdata     <= '0;
      err       <= 1'b0;
    end else begin
      state <= state_nxt;

      if (state == IDLE && any_req) begin
        last      <= grant;
        lat_port  <= grant;
        lat_we    <= sel_we;
        lat_bad   <= sel_bad;
        lat_addr  <= sel_addr;
        lat_wdata <= sel_wdata;
      end

      if (state == ACCESS) begin
        // Writes and rejected accesses return zero read data.
        rdata <= (!lat_we && !lat_bad) ? dm_rdata : '0;
        err   <= lat_bad;
      end
    end
  end

  // Memory-side and handshake outputs decode only from state and latched
  // registers, so there is no path from the request inputs to them.
  assign dm_addr  = lat_addr;
  assign dm_wdata = lat_wdata;
  assign dm_wen   = (state == ACCESS) && lat_we && !lat_bad;
  assign ack0     = (state == DONE) && !lat_port;
  assign ack1     = (state == DONE) &&  lat_port;

endmodule
